// File: rtl/alu_issue_scheduler_pkg.sv
// Shared widths, operator encodings and the reservation-station entry record
// for the ALU issue scheduler.
package alu_issue_scheduler_pkg;

  localparam int OP_W   = 6;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ROB_W  = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9
  } alu_op_e;

  typedef struct packed {
    logic              busy;
    logic [ROB_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } operand_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    operand_t          j;
    operand_t          k;
    logic [ROB_W-1:0]  reorder;
  } entry_t;

  // A pending operand captures a matching broadcast; the ALU channel wins a tag tie.
  function automatic operand_t snoop(input operand_t          opnd,
                                     input logic              alu_en,
                                     input logic [ROB_W-1:0]  alu_tag,
                                     input logic [DATA_W-1:0] alu_val,
                                     input logic              lsb_en,
                                     input logic [ROB_W-1:0]  lsb_tag,
                                     input logic [DATA_W-1:0] lsb_val);
    operand_t res;
    res = opnd;
    if (opnd.busy) begin
      if (alu_en && alu_tag == opnd.tag) begin
        res.busy  = 1'b0;
        res.value = alu_val;
      end else if (lsb_en && lsb_tag == opnd.tag) begin
        res.busy  = 1'b0;
        res.value = lsb_val;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// Dispatch, CDB snoop and ALU issue signals of the scheduler, bundled with
// master (environment) and slave (scheduler) views.
interface alu_issue_scheduler_if;
  import alu_issue_scheduler_pkg::*;

  logic              in_dispatch_valid;
  logic [OP_W-1:0]   in_dispatch_type;
  logic [ADDR_W-1:0] in_dispatch_pc;
  logic [DATA_W-1:0] in_dispatch_imm;
  logic              in_dispatch_qj_busy;
  logic              in_dispatch_qk_busy;
  logic [DATA_W-1:0] in_dispatch_vj;
  logic [DATA_W-1:0] in_dispatch_vk;
  logic [ROB_W-1:0]  in_dispatch_qj;
  logic [ROB_W-1:0]  in_dispatch_qk;
  logic [ROB_W-1:0]  in_dispatch_reorder;
  logic              out_full;

  logic              in_cdb_alu_enable;
  logic [ROB_W-1:0]  in_cdb_alu_reorder;
  logic [DATA_W-1:0] in_cdb_alu_result;
  logic              in_cdb_lsb_enable;
  logic [ROB_W-1:0]  in_cdb_lsb_reorder;
  logic [DATA_W-1:0] in_cdb_lsb_result;

  logic              out_alu_enable;
  logic [OP_W-1:0]   out_alu_type;
  logic [ADDR_W-1:0] out_alu_pc;
  logic [DATA_W-1:0] out_alu_imm;
  logic [DATA_W-1:0] out_alu_rs;
  logic [DATA_W-1:0] out_alu_rt;
  logic [ROB_W-1:0]  out_alu_reorder;

  modport master (
    output in_dispatch_valid, in_dispatch_type, in_dispatch_pc, in_dispatch_imm,
           in_dispatch_qj_busy, in_dispatch_qk_busy, in_dispatch_vj, in_dispatch_vk,
           in_dispatch_qj, in_dispatch_qk, in_dispatch_reorder,
           in_cdb_alu_enable, in_cdb_alu_reorder, in_cdb_alu_result,
           in_cdb_lsb_enable, in_cdb_lsb_reorder, in_cdb_lsb_result,
    input  out_full, out_alu_enable, out_alu_type, out_alu_pc, out_alu_imm,
           out_alu_rs, out_alu_rt, out_alu_reorder
  );

  modport slave (
    input  in_dispatch_valid, in_dispatch_type, in_dispatch_pc, in_dispatch_imm,
           in_dispatch_qj_busy, in_dispatch_qk_busy, in_dispatch_vj, in_dispatch_vk,
           in_dispatch_qj, in_dispatch_qk, in_dispatch_reorder,
           in_cdb_alu_enable, in_cdb_alu_reorder, in_cdb_alu_result,
           in_cdb_lsb_enable, in_cdb_lsb_reorder, in_cdb_lsb_result,
    output out_full, out_alu_enable, out_alu_type, out_alu_pc, out_alu_imm,
           out_alu_rs, out_alu_rt, out_alu_reorder
  );

endinterface

// File: rtl/alu_issue_scheduler_select.sv
// Ready-entry picker: lowest-index ready entry, or oldest ready entry (ties to
// lowest index) when ALU_ISSUE_AGE_EN is defined.
module alu_issue_select
  import alu_issue_scheduler_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            ready,
`ifdef ALU_ISSUE_AGE_EN
  input  logic [DEPTH-1:0][IDX_W-1:0] age,
`endif
  output logic                        found,
  output logic [IDX_W-1:0]            idx
);

`ifdef ALU_ISSUE_AGE_EN
  logic [IDX_W-1:0] best_age;

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || age[i] > best_age)) begin
        found    = 1'b1;
        idx      = IDX_W'(i);
        best_age = age[i];
      end
    end
  end
`else
  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    found = |ready;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) idx = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/alu_issue_scheduler.sv
// Reservation station in front of the ALU: dispatch, dual-CDB wake-up, one
// issue per cycle. Define ALU_ISSUE_AGE_EN for oldest-first selection.
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic                  in_clk,
  input logic                  in_rst,
  input logic                  in_rdy,
  input logic                  in_clear,
  alu_issue_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  entry_t           entries [DEPTH];
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             dispatch_accept;
  entry_t           new_entry;

`ifdef ALU_ISSUE_AGE_EN
  logic [DEPTH-1:0][IDX_W-1:0] age;
`endif

  always_comb begin
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries[i].valid;
      ready_vec[i] = entries[i].valid && !entries[i].j.busy && !entries[i].k.busy;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entries[i].valid) free_idx = IDX_W'(i);
    end
  end

  assign bus.out_full    = &valid_vec;
  assign dispatch_accept = bus.in_dispatch_valid && !bus.out_full;

  // Incoming operands see this cycle's broadcasts, so a same-cycle result is not missed.
  always_comb begin
    new_entry.valid   = 1'b1;
    new_entry.op      = bus.in_dispatch_type;
    new_entry.pc      = bus.in_dispatch_pc;
    new_entry.imm     = bus.in_dispatch_imm;
    new_entry.reorder = bus.in_dispatch_reorder;
    new_entry.j = snoop('{busy: bus.in_dispatch_qj_busy, tag: bus.in_dispatch_qj,
                          value: bus.in_dispatch_vj},
                        bus.in_cdb_alu_enable, bus.in_cdb_alu_reorder, bus.in_cdb_alu_result,
                        bus.in_cdb_lsb_enable, bus.in_cdb_lsb_reorder, bus.in_cdb_lsb_result);
    new_entry.k = snoop('{busy: bus.in_dispatch_qk_busy, tag: bus.in_dispatch_qk,
                          value: bus.in_dispatch_vk},
                        bus.in_cdb_alu_enable, bus.in_cdb_alu_reorder, bus.in_cdb_alu_result,
                        bus.in_cdb_lsb_enable, bus.in_cdb_lsb_reorder, bus.in_cdb_lsb_result);
  end

  alu_issue_select #(.DEPTH(DEPTH)) u_select (
    .ready (ready_vec),
`ifdef ALU_ISSUE_AGE_EN
    .age   (age),
`endif
    .found (sel_found),
    .idx   (sel_idx)
  );

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees start-of-cycle values regardless of statement order.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      // NOTE: the station is a flop array, not a RAM, so it is cleared
      // wholesale; only the valid bits matter functionally.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
`ifdef ALU_ISSUE_AGE_EN
      age <= '0;
`endif
      bus.out_alu_enable  <= 1'b0;
      bus.out_alu_type    <= '0;
      bus.out_alu_pc      <= '0;
      bus.out_alu_imm     <= '0;
      bus.out_alu_rs      <= '0;
      bus.out_alu_rt      <= '0;
      bus.out_alu_reorder <= '0;
    end else if (in_rdy) begin
      if (in_clear) begin
        for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
        bus.out_alu_enable <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          entries[i].j <= snoop(entries[i].j,
                                bus.in_cdb_alu_enable, bus.in_cdb_alu_reorder, bus.in_cdb_alu_result,
                                bus.in_cdb_lsb_enable, bus.in_cdb_lsb_reorder, bus.in_cdb_lsb_result);
          entries[i].k <= snoop(entries[i].k,
                                bus.in_cdb_alu_enable, bus.in_cdb_alu_reorder, bus.in_cdb_alu_result,
                                bus.in_cdb_lsb_enable, bus.in_cdb_lsb_reorder, bus.in_cdb_lsb_result);
        end

        bus.out_alu_enable <= sel_found;
        if (sel_found) begin
          entries[sel_idx].valid <= 1'b0;
          bus.out_alu_type       <= entries[sel_idx].op;
          bus.out_alu_pc         <= entries[sel_idx].pc;
          bus.out_alu_imm        <= entries[sel_idx].imm;
          bus.out_alu_rs         <= entries[sel_idx].j.value;
          bus.out_alu_rt         <= entries[sel_idx].k.value;
          bus.out_alu_reorder    <= entries[sel_idx].reorder;
        end

        // free_idx was free at cycle start, so it never collides with the issuing slot.
        if (dispatch_accept) begin
          entries[free_idx] <= new_entry;
`ifdef ALU_ISSUE_AGE_EN
          for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid) age[i] <= age[i] + 1'b1;
          end
          age[free_idx] <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed self-checking bench for alu_issue_scheduler; expectations follow
// ALU_ISSUE_AGE_EN when the bench is built with that macro.
module tb_alu_issue_scheduler;
  import alu_issue_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_issue_scheduler_if bus_if ();

  alu_issue_scheduler #(.DEPTH(8)) dut (
    .in_clk   (clk),
    .in_rst   (rst),
    .in_rdy   (rdy),
    .in_clear (clear),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus_if.in_dispatch_valid   = 1'b0;
    bus_if.in_dispatch_type    = '0;
    bus_if.in_dispatch_pc      = '0;
    bus_if.in_dispatch_imm     = '0;
    bus_if.in_dispatch_qj_busy = 1'b0;
    bus_if.in_dispatch_qk_busy = 1'b0;
    bus_if.in_dispatch_vj      = '0;
    bus_if.in_dispatch_vk      = '0;
    bus_if.in_dispatch_qj      = '0;
    bus_if.in_dispatch_qk      = '0;
    bus_if.in_dispatch_reorder = '0;
    bus_if.in_cdb_alu_enable   = 1'b0;
    bus_if.in_cdb_alu_reorder  = '0;
    bus_if.in_cdb_alu_result   = '0;
    bus_if.in_cdb_lsb_enable   = 1'b0;
    bus_if.in_cdb_lsb_reorder  = '0;
    bus_if.in_cdb_lsb_result   = '0;
  endtask

  task automatic dispatch(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] pc,
                          input logic [DATA_W-1:0] imm,
                          input logic jb, input logic [ROB_W-1:0] qj, input logic [DATA_W-1:0] vj,
                          input logic kb, input logic [ROB_W-1:0] qk, input logic [DATA_W-1:0] vk,
                          input logic [ROB_W-1:0] rob);
    bus_if.in_dispatch_valid   = 1'b1;
    bus_if.in_dispatch_type    = op;
    bus_if.in_dispatch_pc      = pc;
    bus_if.in_dispatch_imm     = imm;
    bus_if.in_dispatch_qj_busy = jb;
    bus_if.in_dispatch_qj      = qj;
    bus_if.in_dispatch_vj      = vj;
    bus_if.in_dispatch_qk_busy = kb;
    bus_if.in_dispatch_qk      = qk;
    bus_if.in_dispatch_vk      = vk;
    bus_if.in_dispatch_reorder = rob;
  endtask

  task automatic do_reset;
    idle_inputs();
    rdy   = 1'b1;
    clear = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_enable: got %0b want 0", bus_if.out_alu_enable);
    end
    n_checks++;
    if (bus_if.out_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full: got %0b want 0", bus_if.out_full);
    end
    n_checks++;
    if ({bus_if.out_alu_rs, bus_if.out_alu_rt, bus_if.out_alu_imm, bus_if.out_alu_pc,
         bus_if.out_alu_type, bus_if.out_alu_reorder} !== '0) begin
      n_fail++; $display("FAIL reset_data: rs=%h rt=%h want all zero", bus_if.out_alu_rs, bus_if.out_alu_rt);
    end
  endtask

  task automatic test_ready_dispatch;
    do_reset();
    dispatch(OP_ADD, 32'h100, 32'h11, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
    tick();
    idle_inputs();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0) begin
      n_fail++; $display("FAIL add_latency_e0: got enable %0b want 0", bus_if.out_alu_enable);
    end
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b1 || bus_if.out_alu_rs !== 32'd5 || bus_if.out_alu_rt !== 32'd7 ||
        bus_if.out_alu_reorder !== 4'd3) begin
      n_fail++; $display("FAIL add_issue: got en=%0b rs=%0d rt=%0d rob=%0d want en=1 rs=5 rt=7 rob=3",
                         bus_if.out_alu_enable, bus_if.out_alu_rs, bus_if.out_alu_rt, bus_if.out_alu_reorder);
    end
    n_checks++;
    if (bus_if.out_alu_type !== OP_ADD || bus_if.out_alu_pc !== 32'h100 || bus_if.out_alu_imm !== 32'h11) begin
      n_fail++; $display("FAIL add_fields: got type=%0d pc=%h imm=%h want type=0 pc=100 imm=11",
                         bus_if.out_alu_type, bus_if.out_alu_pc, bus_if.out_alu_imm);
    end
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0 || bus_if.out_alu_rs !== 32'd5) begin
      n_fail++; $display("FAIL add_after: got en=%0b rs=%0d want en=0 rs=5 (held)",
                         bus_if.out_alu_enable, bus_if.out_alu_rs);
    end
  endtask

  task automatic test_lsb_wakeup;
    do_reset();
    dispatch(OP_SUB, 32'h200, 32'h0, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd1, 4'd5);
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0) begin
      n_fail++; $display("FAIL sub_waiting: got enable %0b want 0", bus_if.out_alu_enable);
    end
    bus_if.in_cdb_lsb_enable  = 1'b1;
    bus_if.in_cdb_lsb_reorder = 4'd2;
    bus_if.in_cdb_lsb_result  = 32'd10;
    tick();
    idle_inputs();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0) begin
      n_fail++; $display("FAIL sub_wake_edge: got enable %0b want 0", bus_if.out_alu_enable);
    end
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b1 || bus_if.out_alu_rs !== 32'd10 || bus_if.out_alu_rt !== 32'd1 ||
        bus_if.out_alu_type !== OP_SUB || bus_if.out_alu_reorder !== 4'd5) begin
      n_fail++; $display("FAIL sub_issue: got en=%0b rs=%0d rt=%0d type=%0d rob=%0d want 1 10 1 1 5",
                         bus_if.out_alu_enable, bus_if.out_alu_rs, bus_if.out_alu_rt,
                         bus_if.out_alu_type, bus_if.out_alu_reorder);
    end
  endtask

  task automatic test_bypass;
    do_reset();
    dispatch(OP_AND, 32'h300, 32'h0, 1'b0, 4'd0, 32'd3, 1'b1, 4'd4, 32'd0, 4'd6);
    bus_if.in_cdb_alu_enable  = 1'b1;
    bus_if.in_cdb_alu_reorder = 4'd4;
    bus_if.in_cdb_alu_result  = 32'hFF;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b1 || bus_if.out_alu_rt !== 32'hFF || bus_if.out_alu_rs !== 32'd3) begin
      n_fail++; $display("FAIL bypass_issue: got en=%0b rs=%h rt=%h want en=1 rs=3 rt=ff",
                         bus_if.out_alu_enable, bus_if.out_alu_rs, bus_if.out_alu_rt);
    end
  endtask

  task automatic test_full;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dispatch(OP_OR, 32'(i), 32'h0, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'(i), 4'(i));
      tick();
    end
    idle_inputs();
    n_checks++;
    if (bus_if.out_full !== 1'b1) begin
      n_fail++; $display("FAIL full_set: got %0b want 1", bus_if.out_full);
    end
    dispatch(OP_OR, 32'h99, 32'h0, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd9, 4'd9);
    tick();
    idle_inputs();
    n_checks++;
    if (bus_if.out_full !== 1'b1 || bus_if.out_alu_enable !== 1'b0) begin
      n_fail++; $display("FAIL full_drop: got full=%0b en=%0b want full=1 en=0",
                         bus_if.out_full, bus_if.out_alu_enable);
    end
    bus_if.in_cdb_alu_enable  = 1'b1;
    bus_if.in_cdb_alu_reorder = 4'd6;
    bus_if.in_cdb_alu_result  = 32'd100;
    bus_if.in_cdb_lsb_enable  = 1'b1;
    bus_if.in_cdb_lsb_reorder = 4'd6;
    bus_if.in_cdb_lsb_result  = 32'd200;
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (bus_if.out_alu_enable !== 1'b1 || bus_if.out_alu_reorder !== 4'(i) ||
          bus_if.out_alu_rs !== 32'd100 || bus_if.out_alu_rt !== 32'(i)) begin
        n_fail++; $display("FAIL full_drain[%0d]: got en=%0b rob=%0d rs=%0d rt=%0d want en=1 rob=%0d rs=100 rt=%0d",
                           i, bus_if.out_alu_enable, bus_if.out_alu_reorder, bus_if.out_alu_rs,
                           bus_if.out_alu_rt, i, i);
      end
      if (i == 0) begin
        n_checks++;
        if (bus_if.out_full !== 1'b0) begin
          n_fail++; $display("FAIL full_release: got %0b want 0", bus_if.out_full);
        end
      end
    end
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0) begin
      n_fail++; $display("FAIL full_empty: got enable %0b want 0", bus_if.out_alu_enable);
    end
  endtask

  task automatic test_clear;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      dispatch(OP_XOR, 32'h0, 32'h0, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
      tick();
    end
    idle_inputs();
    bus_if.in_cdb_lsb_enable  = 1'b1;
    bus_if.in_cdb_lsb_reorder = 4'd5;
    bus_if.in_cdb_lsb_result  = 32'd1;
    tick();
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0 || bus_if.out_full !== 1'b0) begin
      n_fail++; $display("FAIL clear_edge: got en=%0b full=%0b want 0 0",
                         bus_if.out_alu_enable, bus_if.out_full);
    end
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0) begin
      n_fail++; $display("FAIL clear_after: got enable %0b want 0", bus_if.out_alu_enable);
    end
  endtask

  task automatic test_rdy_hold;
    do_reset();
    dispatch(OP_ADD, 32'h400, 32'h0, 1'b0, 4'd0, 32'd42, 1'b0, 4'd0, 32'd43, 4'd7);
    tick();
    idle_inputs();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus_if.out_alu_enable !== 1'b0) begin
        n_fail++; $display("FAIL rdy_stall[%0d]: got enable %0b want 0", i, bus_if.out_alu_enable);
      end
    end
    rdy = 1'b1;
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b1 || bus_if.out_alu_rs !== 32'd42) begin
      n_fail++; $display("FAIL rdy_resume: got en=%0b rs=%0d want en=1 rs=42",
                         bus_if.out_alu_enable, bus_if.out_alu_rs);
    end
    rdy = 1'b0;
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b1 || bus_if.out_alu_reorder !== 4'd7) begin
      n_fail++; $display("FAIL rdy_hold_out: got en=%0b rob=%0d want en=1 rob=7",
                         bus_if.out_alu_enable, bus_if.out_alu_reorder);
    end
    rdy = 1'b1;
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0) begin
      n_fail++; $display("FAIL rdy_drain: got enable %0b want 0", bus_if.out_alu_enable);
    end
  endtask

  task automatic test_issue_order;
    logic [ROB_W-1:0]  first_rob, second_rob;
    logic [DATA_W-1:0] first_rs, second_rs;
`ifdef ALU_ISSUE_AGE_EN
    first_rob = 4'd11; first_rs = 32'd70; second_rob = 4'd12; second_rs = 32'd90;
`else
    first_rob = 4'd12; first_rs = 32'd90; second_rob = 4'd11; second_rs = 32'd70;
`endif
    do_reset();
    dispatch(OP_SLT, 32'h0, 32'h0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0, 4'd10);
    tick();
    dispatch(OP_SLT, 32'h0, 32'h0, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd0, 4'd11);
    tick();
    idle_inputs();
    bus_if.in_cdb_lsb_enable  = 1'b1;
    bus_if.in_cdb_lsb_reorder = 4'd9;
    bus_if.in_cdb_lsb_result  = 32'd1;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b1 || bus_if.out_alu_reorder !== 4'd10) begin
      n_fail++; $display("FAIL order_first_slot0: got en=%0b rob=%0d want en=1 rob=10",
                         bus_if.out_alu_enable, bus_if.out_alu_reorder);
    end
    dispatch(OP_SLT, 32'h0, 32'h0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0, 4'd12);
    tick();
    idle_inputs();
    bus_if.in_cdb_alu_enable  = 1'b1;
    bus_if.in_cdb_alu_reorder = 4'd7;
    bus_if.in_cdb_alu_result  = 32'd70;
    bus_if.in_cdb_lsb_enable  = 1'b1;
    bus_if.in_cdb_lsb_reorder = 4'd9;
    bus_if.in_cdb_lsb_result  = 32'd90;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b1 || bus_if.out_alu_reorder !== first_rob || bus_if.out_alu_rs !== first_rs) begin
      n_fail++; $display("FAIL order_pick1: got en=%0b rob=%0d rs=%0d want en=1 rob=%0d rs=%0d",
                         bus_if.out_alu_enable, bus_if.out_alu_reorder, bus_if.out_alu_rs, first_rob, first_rs);
    end
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b1 || bus_if.out_alu_reorder !== second_rob || bus_if.out_alu_rs !== second_rs) begin
      n_fail++; $display("FAIL order_pick2: got en=%0b rob=%0d rs=%0d want en=1 rob=%0d rs=%0d",
                         bus_if.out_alu_enable, bus_if.out_alu_reorder, bus_if.out_alu_rs, second_rob, second_rs);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    dispatch(OP_ADD, 32'h500, 32'h0, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0, 32'd9, 4'd2);
    tick();
    dispatch(OP_ADD, 32'h504, 32'h0, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd1, 4'd4);
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0 || bus_if.out_alu_rs !== 32'd0 || bus_if.out_full !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got en=%0b rs=%0d full=%0b want 0 0 0",
                         bus_if.out_alu_enable, bus_if.out_alu_rs, bus_if.out_full);
    end
    rst = 1'b0;
    bus_if.in_cdb_lsb_enable  = 1'b1;
    bus_if.in_cdb_lsb_reorder = 4'd3;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (bus_if.out_alu_enable !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_flushed: got enable %0b want 0", bus_if.out_alu_enable);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ready_dispatch();
    test_lsb_wakeup();
    test_bypass();
    test_full();
    test_clear();
    test_rdy_hold();
    test_issue_order();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
